// File: rtl/csa_nibble_seq.sv
// rtl/csa_nibble_seq.sv - WIDTH-bit adder sequenced one nibble per clock through a 4-bit carry-select adder.
// Optional subtract mode enabled by defining CSA_SEQ_SUB_EN.

module csa4 (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Cin,
  output logic [3:0] sum,
  output logic       Cout
);
  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  // Upper pair is computed for both carry-ins and picked by the lower pair's carry.
  assign lo   = {1'b0, X[1:0]} + {1'b0, Y[1:0]} + {2'b00, Cin};
  assign hi0  = {1'b0, X[3:2]} + {1'b0, Y[3:2]};
  assign hi1  = hi0 + 3'd1;
  assign sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
  assign Cout = lo[2] ? hi1[2] : hi0[2];
endmodule

module csa_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CSA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r, b_eff;
  logic [IW-1:0]    idx;
  logic             carry, cout_r, cin_eff, last;
  logic [3:0]       nib_sum;
  logic             nib_cout;

`ifdef CSA_SEQ_SUB_EN
  // Subtraction is a + ~b + 1; cout then means "no borrow".
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign last = (idx == IW'(NIB - 1));

  csa4 u_csa4 (
    .X    (a_sh[3:0]),
    .Y    (b_sh[3:0]),
    .Cin  (carry),
    .sum  (nib_sum),
    .Cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Operands shift right so the adder always sees nibble 0 of the shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
          end
        end
        RUN: begin
          a_sh                   <= a_sh >> 4;
          b_sh                   <= b_sh >> 4;
          sum_r[{idx, 2'b00} +: 4] <= nib_sum;
          carry                  <= nib_cout;
          idx                    <= idx + 1'b1;
          if (last) cout_r <= nib_cout;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
endmodule

// File: tb/tb_csa_nibble_seq.sv
// tb/tb_csa_nibble_seq.sv - scoreboard bench for csa_nibble_seq; covers subtract mode when CSA_SEQ_SUB_EN is defined.

module tb_csa_nibble_seq;
  localparam int W   = 16;
  localparam int NB  = W / 4;
  localparam int GAP = NB + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef CSA_SEQ_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           dc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  csa_nibble_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CSA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
    logic [W-1:0] d;
    if (sb) begin
      d = x - y;
      return {(x >= y), d};
    end
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 sum=%0h (cycle %0d)", sum, cyc);
      end else begin
        mon_e = q.pop_front();
        check("sum", {48'd0, sum}, {48'd0, mon_e.s});
        check("cout", {63'd0, cout}, {63'd0, mon_e.c});
        check("done_cycle", cyc, mon_e.dc);
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at the first cycle a new start can be accepted.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic sb, input logic [W:0] ex);
    exp_t e;
    a = x;
    b = y;
    cin = ci;
`ifdef CSA_SEQ_SUB_EN
    sub = sb;
`endif
    start = 1'b1;
    e.s = ex[W-1:0];
    e.c = ex[W];
    e.dc = cyc + 1 + NB;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
`ifdef CSA_SEQ_SUB_EN
    sub = ~sb;
`endif
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    while (cyc < e.dc + 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    exp_t e;
    logic [W-1:0] x, y;
    logic ci, sb;

    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_sum", {48'd0, sum}, 64'd0);
    check("reset_cout", {63'd0, cout}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(16'h1234, 16'h0FCD, 1'b0, 1'b0, {1'b0, 16'h2201});
    launch(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 16'h0000});
    launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 16'hFFFF});

    // start held with other operands through RUN and DONE must be ignored
    c = cyc;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    e.s = 16'h0002; e.c = 1'b0; e.dc = c + 1 + NB;
    q.push_back(e);
    @(negedge clk);
    a = 16'h00F0; b = 16'h000F;
    while (cyc < c + NB + 1) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ignored_start_idle", {63'd0, busy}, 64'd0);

    // asynchronous reset in the second RUN cycle
    c = cyc;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_sum", {48'd0, sum}, 64'd0);
    check("arst_cout", {63'd0, cout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(16'h0010, 16'h0020, 1'b0, 1'b0, {1'b0, 16'h0030});

    // start held high: one accept every GAP cycles, busy low one cycle between
    c = cyc;
    a = 16'h0123; b = 16'h0456; cin = 1'b1; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.s = 16'h057A; e.c = 1'b0; e.dc = c + 1 + NB + k * GAP;
      q.push_back(e);
    end
    while (cyc < c + 3 * GAP) begin
      check("busy_hold", {63'd0, busy}, (((cyc - c) % GAP) == 0) ? 64'd0 : 64'd1);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    check("busy_hold_end", {63'd0, busy}, 64'd0);

`ifdef CSA_SEQ_SUB_EN
    launch(16'd5, 16'd7, 1'b0, 1'b1, {1'b0, 16'hFFFE});
    launch(16'd7, 16'd5, 1'b0, 1'b1, {1'b1, 16'h0002});
    launch(16'd5, 16'd7, 1'b1, 1'b1, {1'b0, 16'hFFFE});
    launch(16'd7, 16'd5, 1'b1, 1'b1, {1'b1, 16'h0002});
    launch(16'd7, 16'd5, 1'b1, 1'b0, {1'b0, 16'h000D});
`endif

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      x = W'($urandom);
      y = W'($urandom);
      ci = 1'($urandom);
`ifdef CSA_SEQ_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      launch(x, y, ci, sb, model(x, y, ci, sb));
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
